// File: rtl/sys_ctrl_pkg.sv
// Shared encodings for the system-controller send path: FSM states,
// response type codes and default frame headers.
package sys_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PRESENT = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef enum logic {
    RESP_RD  = 1'b0,
    RESP_ALU = 1'b1
  } resp_t;

  localparam logic [7:0] HDR_RD_DEF  = 8'hA5;
  localparam logic [7:0] HDR_ALU_DEF = 8'h5A;

endpackage

// File: rtl/sys_ctrl_resp_fifo.sv
// Response queue: dual push (read entry ordered before ALU entry), single pop.
// A pop in the same cycle frees its slot before the pushes are judged.
module sys_ctrl_resp_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push_rd,
  input  logic [W-1:0] rd_entry,
  input  logic         push_alu,
  input  logic [W-1:0] alu_entry,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, free;
  logic          pop_ok, rd_ok, alu_ok;

  always_comb begin
    pop_ok = pop && (count != '0);
    free   = CW'(DEPTH) - count + CW'(pop_ok);
    rd_ok  = push_rd && (free != '0);
    alu_ok = push_alu && (free > CW'(rd_ok));
  end

  assign empty = (count == '0);
  assign drop  = (push_rd && !rd_ok) || (push_alu && !alu_ok);
  assign head  = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(rd_ok) + PW'(alu_ok);
      rd_ptr <= rd_ptr + PW'(pop_ok);
      count  <= count + CW'(rd_ok) + CW'(alu_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge CLK) begin
    if (rd_ok)  mem[wr_ptr]                <= rd_entry;
    if (alu_ok) mem[wr_ptr + PW'(rd_ok)]   <= alu_entry;
  end

endmodule

// File: rtl/sys_ctrl_tx_framer.sv
// Queues register-read and ALU responses and serialises them byte-by-byte to
// the UART TX using a Busy rising-edge handshake, with optional header/XOR framing.
module sys_ctrl_tx_framer
  import sys_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ALU_BYTES  = 2,
  parameter int                    RESP_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] HDR_RD     = HDR_RD_DEF,
  parameter logic [DATA_WIDTH-1:0] HDR_ALU    = HDR_ALU_DEF
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH*ALU_BYTES-1:0] ALU_OUT,
  input  logic                            OUT_Valid,
  input  logic [DATA_WIDTH-1:0]           RdData,
  input  logic                            RdData_Valid,
  input  logic                            FRAME_EN,
  input  logic                            Busy,
  output logic [DATA_WIDTH-1:0]           TX_P_DATA,
  output logic                            TX_D_VLD,
  output logic                            alu_out_done,
  output logic                            rd_done,
  output logic                            resp_drop
);

  localparam int PL_W = DATA_WIDTH * ALU_BYTES;
  localparam int IW   = $clog2(ALU_BYTES + 2);

  state_t                state, state_nxt;
  resp_t                 cur_type, type_nxt;
  logic [PL_W-1:0]       cur_pl, pl_nxt;
  logic                  cur_frm, frm_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [DATA_WIDTH-1:0] csum, csum_nxt, cur_byte;
  logic [PL_W:0]         head;
  logic                  busy_q, busy_rise, pop, fifo_empty, fifo_drop, last;

  function automatic int frame_len(resp_t t, logic f);
    return ((t == RESP_ALU) ? ALU_BYTES : 1) + (f ? 2 : 0);
  endfunction

  function automatic logic is_payload(resp_t t, logic f, logic [IW-1:0] i);
    if (!f) return 1'b1;
    return (int'(i) >= 1) && (int'(i) <= frame_len(t, f) - 2);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] byte_at(resp_t t, logic f, logic [IW-1:0] i,
                                                    logic [PL_W-1:0] pl,
                                                    logic [DATA_WIDTH-1:0] c);
    int              k;
    logic [PL_W-1:0] sh;
    if (f && (i == '0)) return (t == RESP_ALU) ? HDR_ALU : HDR_RD;
    if (f && (int'(i) == frame_len(t, f) - 1)) return c;
    k  = f ? int'(i) - 1 : int'(i);
    sh = pl >> (k * DATA_WIDTH);
    return sh[DATA_WIDTH-1:0];
  endfunction

  sys_ctrl_resp_fifo #(
    .W     (PL_W + 1),
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push_rd   (RdData_Valid),
    .rd_entry  ({RESP_RD, PL_W'(RdData)}),
    .push_alu  (OUT_Valid),
    .alu_entry ({RESP_ALU, ALU_OUT}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign busy_rise = Busy && !busy_q;
  assign cur_byte  = byte_at(cur_type, cur_frm, idx, cur_pl, csum);
  assign last      = (int'(idx) == frame_len(cur_type, cur_frm) - 1);

  always_comb begin
    state_nxt = state;
    type_nxt  = cur_type;
    pl_nxt    = cur_pl;
    frm_nxt   = cur_frm;
    idx_nxt   = idx;
    csum_nxt  = csum;
    pop       = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nxt = ST_LOAD;
      ST_LOAD: begin
        pop       = 1'b1;
        type_nxt  = resp_t'(head[PL_W]);
        pl_nxt    = head[PL_W-1:0];
        frm_nxt   = FRAME_EN;
        idx_nxt   = '0;
        csum_nxt  = '0;
        state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        // Only a fresh 0->1 transition counts; a Busy held high is ignored.
        if (busy_rise) begin
          if (is_payload(cur_type, cur_frm, idx)) csum_nxt = csum ^ cur_byte;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!Busy) begin
          if (last) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt   = idx + IW'(1);
            state_nxt = ST_PRESENT;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      idx          <= '0;
      csum         <= '0;
      busy_q       <= 1'b0;
      TX_D_VLD     <= 1'b0;
      TX_P_DATA    <= '0;
      alu_out_done <= 1'b0;
      rd_done      <= 1'b0;
      resp_drop    <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      csum         <= csum_nxt;
      busy_q       <= Busy;
      TX_D_VLD     <= (state_nxt == ST_PRESENT);
      // Output byte is computed from next-state values so it is ready the cycle PRESENT starts.
      TX_P_DATA    <= (state_nxt == ST_PRESENT) ?
                      byte_at(type_nxt, frm_nxt, idx_nxt, pl_nxt, csum_nxt) : '0;
      alu_out_done <= (state_nxt == ST_DONE) && (cur_type == RESP_ALU);
      rd_done      <= (state_nxt == ST_DONE) && (cur_type == RESP_RD);
      resp_drop    <= fifo_drop;
    end
  end

  always_ff @(posedge CLK) begin
    cur_type <= type_nxt;
    cur_pl   <= pl_nxt;
    cur_frm  <= frm_nxt;
  end

endmodule
